// File: rtl/microwave_timer.sv
// microwave_timer: BCD MM:SS countdown timer with keypad entry and a prescaled second tick
// Ports: clk/rst (sync, active-high) | clearn: active-low clear | mag_on: count enable
//   digit_valid/digit: keypad BCD entry, shifted in from the right
//   time_bcd: {min_tens, min_ones, sec_tens, sec_ones} | timer_done: time_bcd == 0000
//   done_pulse: one cycle when the countdown reaches zero | running: FSM in COUNT
module microwave_timer #(
  parameter int TICK_DIV = 100
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        clearn,
  input  logic        mag_on,
  input  logic        digit_valid,
  input  logic [3:0]  digit,
  output logic [15:0] time_bcd,
  output logic        timer_done,
  output logic        done_pulse,
  output logic        running
);
  localparam int PW = $clog2(TICK_DIV);
  localparam logic [PW-1:0] LAST = PW'(TICK_DIV - 1);
  localparam logic [1:0] IDLE = 2'd0, COUNT = 2'd1, EXPIRED = 2'd2;
  logic [1:0]    state;
  logic [PW-1:0] pre;
  logic          accept;
  logic          tick;
  logic [15:0]   shifted;
  logic [15:0]   dec;
  assign accept     = state != COUNT && !mag_on && digit_valid && digit <= 4'd9;
  assign tick       = state == COUNT && mag_on && pre == LAST;
  assign shifted    = {time_bcd[11:0], digit};
  assign timer_done = time_bcd == 16'h0000;
  assign running    = state == COUNT;
  // Borrow chain: seconds are treated as plain BCD, so 90 counts down without normalising.
  // Minutes are nonzero whenever seconds are 00 in COUNT, since 0000 never stays in COUNT.
  always_comb begin
    dec = time_bcd;
    if (time_bcd[3:0] != 4'd0)
      dec[3:0] = time_bcd[3:0] - 4'd1;
    else if (time_bcd[7:4] != 4'd0)
      dec[7:0] = {time_bcd[7:4] - 4'd1, 4'd9};
    else begin
      dec[7:0]  = 8'h59;
      dec[15:8] = time_bcd[11:8] != 4'd0 ? {time_bcd[15:12], time_bcd[11:8] - 4'd1}
                                         : {time_bcd[15:12] - 4'd1, 4'd9};
    end
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      time_bcd   <= 16'h0000;
      pre        <= '0;
      done_pulse <= 1'b0;
    end else begin
      done_pulse <= 1'b0;
      if (!clearn) begin
        state    <= IDLE;
        time_bcd <= 16'h0000;
        pre      <= '0;
      end else begin
        case (state)
          IDLE: begin
            pre <= '0;
            if (accept)
              time_bcd <= shifted;
            else if (mag_on && time_bcd != 16'h0000)
              state <= COUNT;
          end
          COUNT: begin
            // Pausing drops any partial second, including a tick due this very cycle.
            if (!mag_on) begin
              state <= IDLE;
              pre   <= '0;
            end else if (tick) begin
              pre      <= '0;
              time_bcd <= dec;
              if (dec == 16'h0000) begin
                state      <= EXPIRED;
                done_pulse <= 1'b1;
              end
            end else
              pre <= pre + 1'b1;
          end
          EXPIRED: begin
            pre <= '0;
            if (accept) begin
              time_bcd <= shifted;
              state    <= IDLE;
            end
          end
          default: begin
            state <= IDLE;
            pre   <= '0;
          end
        endcase
      end
    end
  end
endmodule

// File: tb/tb_microwave_timer.sv
// tb_microwave_timer: table, directed and randomized checks of microwave_timer against a time-arithmetic model
module tb_microwave_timer;
  localparam int TD = 4;
  logic        clk = 1'b0;
  logic        rst, clearn, mag_on, digit_valid;
  logic [3:0]  digit;
  logic [15:0] time_bcd;
  logic        timer_done, done_pulse, running;
  int n_cmp = 0, n_bad = 0;
  int m_mode = 0, m_min = 0, m_sec = 0, m_ct = 0;
  bit m_pulse = 1'b0;
  int pulses;
  typedef struct {
    logic r, c, m, v;
    logic [3:0] d;
    logic [15:0] t;
    logic dn, p, run;
  } vec_t;
  vec_t tbl[13];
  always #5 clk = ~clk;
  microwave_timer #(.TICK_DIV(TD)) dut (
    .clk(clk), .rst(rst), .clearn(clearn), .mag_on(mag_on),
    .digit_valid(digit_valid), .digit(digit), .time_bcd(time_bcd),
    .timer_done(timer_done), .done_pulse(done_pulse), .running(running)
  );
  function automatic logic [15:0] to_bcd(input int mm, input int ss);
    return {4'(mm / 10), 4'(mm % 10), 4'(ss / 10), 4'(ss % 10)};
  endfunction
  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, want %h at %0t", name, act, exp, $time);
    end
  endtask
  // Model works on minutes/seconds as integers; mode 0 idle, 1 counting, 2 expired.
  task automatic model_step(input bit r, c, m, v, input logic [3:0] d);
    bit ok;
    ok = v && !m && d <= 4'd9 && m_mode != 1;
    m_pulse = 1'b0;
    if (r) begin
      m_mode = 0; m_min = 0; m_sec = 0; m_ct = 0;
    end else if (!c) begin
      m_mode = 0; m_min = 0; m_sec = 0; m_ct = 0;
    end else if (m_mode == 1) begin
      if (!m) begin
        m_mode = 0; m_ct = 0;
      end else if (++m_ct == TD) begin
        m_ct = 0;
        if (m_sec > 0) m_sec--;
        else begin m_sec = 59; m_min--; end
        if (m_min == 0 && m_sec == 0) begin m_mode = 2; m_pulse = 1'b1; end
      end
    end else if (ok) begin
      m_min = (m_min % 10) * 10 + m_sec / 10;
      m_sec = (m_sec % 10) * 10 + int'(d);
      m_mode = 0;
    end else if (m_mode == 0 && m && (m_min != 0 || m_sec != 0)) begin
      m_mode = 1; m_ct = 0;
    end
  endtask
  task automatic cyc(input bit r, c, m, v, input logic [3:0] d);
    rst = r; clearn = c; mag_on = m; digit_valid = v; digit = d;
    model_step(r, c, m, v, d);
    @(posedge clk);
    #1;
    check("model_time", time_bcd, to_bcd(m_min, m_sec));
    check("model_done", 16'(timer_done), 16'(m_min == 0 && m_sec == 0));
    check("model_pulse", 16'(done_pulse), 16'(m_pulse));
    check("model_running", 16'(running), 16'(m_mode == 1));
    if (done_pulse) pulses++;
  endtask
  task automatic load(input int mm, input int ss);
    cyc(0, 0, 0, 0, 4'd0);
    cyc(0, 1, 0, 1, 4'(mm / 10));
    cyc(0, 1, 0, 1, 4'(mm % 10));
    cyc(0, 1, 0, 1, 4'(ss / 10));
    cyc(0, 1, 0, 1, 4'(ss % 10));
  endtask
  task automatic run(input int n);
    repeat (n) cyc(0, 1, 1, 0, 4'd0);
  endtask
  initial begin
    bit rm;
    tbl[0]  = '{1'b1, 1'b1, 1'b0, 1'b0, 4'h0, 16'h0000, 1'b1, 1'b0, 1'b0};
    tbl[1]  = '{1'b0, 1'b1, 1'b0, 1'b1, 4'h1, 16'h0001, 1'b0, 1'b0, 1'b0};
    tbl[2]  = '{1'b0, 1'b1, 1'b0, 1'b1, 4'h3, 16'h0013, 1'b0, 1'b0, 1'b0};
    tbl[3]  = '{1'b0, 1'b1, 1'b0, 1'b1, 4'hA, 16'h0013, 1'b0, 1'b0, 1'b0};
    tbl[4]  = '{1'b0, 1'b1, 1'b1, 1'b1, 4'h5, 16'h0013, 1'b0, 1'b0, 1'b1};
    tbl[5]  = '{1'b0, 1'b1, 1'b1, 1'b0, 4'h0, 16'h0013, 1'b0, 1'b0, 1'b1};
    tbl[6]  = '{1'b0, 1'b1, 1'b1, 1'b0, 4'h0, 16'h0013, 1'b0, 1'b0, 1'b1};
    tbl[7]  = '{1'b0, 1'b1, 1'b1, 1'b0, 4'h0, 16'h0013, 1'b0, 1'b0, 1'b1};
    tbl[8]  = '{1'b0, 1'b1, 1'b1, 1'b0, 4'h0, 16'h0012, 1'b0, 1'b0, 1'b1};
    tbl[9]  = '{1'b0, 1'b1, 1'b0, 1'b0, 4'h0, 16'h0012, 1'b0, 1'b0, 1'b0};
    tbl[10] = '{1'b0, 1'b0, 1'b0, 1'b0, 4'h0, 16'h0000, 1'b1, 1'b0, 1'b0};
    tbl[11] = '{1'b0, 1'b1, 1'b1, 1'b0, 4'h0, 16'h0000, 1'b1, 1'b0, 1'b0};
    tbl[12] = '{1'b0, 1'b1, 1'b0, 1'b1, 4'h9, 16'h0009, 1'b0, 1'b0, 1'b0};
    pulses = 0;
    for (int i = 0; i < 13; i++) begin
      cyc(tbl[i].r, tbl[i].c, tbl[i].m, tbl[i].v, tbl[i].d);
      check($sformatf("tbl%0d_time", i), time_bcd, tbl[i].t);
      check($sformatf("tbl%0d_done", i), 16'(timer_done), 16'(tbl[i].dn));
      check($sformatf("tbl%0d_pulse", i), 16'(done_pulse), 16'(tbl[i].p));
      check($sformatf("tbl%0d_running", i), 16'(running), 16'(tbl[i].run));
    end
    // Full countdown from 0013 with a single completion pulse.
    load(0, 13);
    pulses = 0;
    run(1);
    for (int k = 1; k <= 13; k++) begin
      run(TD);
      check("cd_time", time_bcd, to_bcd(0, 13 - k));
      check("cd_pulse", 16'(done_pulse), 16'(k == 13));
    end
    run(3);
    check("cd_pulses", 16'(pulses), 16'd1);
    check("exp_hold", time_bcd, 16'h0000);
    check("exp_running", 16'(running), 16'd0);
    cyc(0, 1, 0, 1, 4'd7);
    check("exp_digit", time_bcd, 16'h0007);
    run(1 + TD);
    check("exp_restart", time_bcd, 16'h0006);
    // Minute borrow and seconds above 59.
    load(1, 0);
    run(1 + TD);
    check("borrow_1", time_bcd, 16'h0059);
    run(TD);
    check("borrow_2", time_bcd, 16'h0058);
    load(0, 90);
    run(1 + TD);
    check("sec90", time_bcd, 16'h0089);
    // Pause and resume restarts the full second.
    load(0, 5);
    run(1 + 2 * TD);
    check("pause_pre", time_bcd, 16'h0003);
    repeat (10) cyc(0, 1, 0, 0, 4'd0);
    check("pause_hold", time_bcd, 16'h0003);
    check("pause_running", 16'(running), 16'd0);
    run(TD);
    check("resume_early", time_bcd, 16'h0003);
    run(1);
    check("resume_dec", time_bcd, 16'h0002);
    // mag_on drops exactly on a tick: the tick is lost.
    load(0, 5);
    run(TD);
    cyc(0, 1, 0, 0, 4'd0);
    check("drop_tick", time_bcd, 16'h0005);
    // Digit entry while running, invalid digit, five-digit overflow.
    run(3);
    cyc(0, 1, 1, 1, 4'd7);
    check("run_digit", time_bcd, 16'h0005);
    cyc(0, 1, 0, 1, 4'hA);
    check("bad_digit", time_bcd, 16'h0005);
    cyc(0, 0, 0, 0, 4'd0);
    for (int i = 1; i <= 5; i++) cyc(0, 1, 0, 1, 4'(i));
    check("five_digits", time_bcd, 16'h2345);
    // Clear mid-count, then mag_on with zero time.
    load(0, 13);
    pulses = 0;
    run(6);
    cyc(0, 0, 1, 0, 4'd0);
    check("clr_time", time_bcd, 16'h0000);
    check("clr_running", 16'(running), 16'd0);
    run(6);
    check("zero_running", 16'(running), 16'd0);
    // Clear on the expiring tick.
    load(0, 1);
    run(TD);
    cyc(0, 0, 1, 0, 4'd0);
    check("clr_tick", time_bcd, 16'h0000);
    check("clr_tick_pulses", 16'(pulses), 16'd0);
    // Reset mid-count.
    load(0, 42);
    run(3);
    cyc(1, 1, 1, 0, 4'd0);
    check("rst_time", time_bcd, 16'h0000);
    check("rst_running", 16'(running), 16'd0);
    // Randomized traffic against the model.
    rm = 1'b0;
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(29) == 0) rm = ~rm;
      cyc($urandom_range(299) == 0, $urandom_range(79) != 0, rm,
          $urandom_range(3) == 0, 4'($urandom_range(15)));
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
